spi_to_jpeg_data: RTL and testbench
===================================

Name: spi_to_jpeg_data

Overview:
- Host-to-encoder ingress path, the inverse of the JPEG-to-SPI readout.
- Accepts raw pixel bytes strobed in from the SPI slave and writes them, in raster order, into the encoder frame buffer (WIDTH x HEIGHT x BPP bytes).
- After the last byte of a frame lands, it pulses je_start, holds off the host until the encoder reports je_done, then returns to idle for the next frame.

Parameters:
- WIDTH, 320, pixels per row.
- HEIGHT, 200, rows per frame.
- BPP, 2, bytes per pixel (1 or 2 supported).
- SWAP_BYTES, 0, when 1 and BPP=2, the two bytes of each pixel are written in swapped order: byte 0 goes to offset 1 and byte 1 goes to offset 0.
- ADDR_W, 17, frame buffer address width; must satisfy WIDTH*HEIGHT*BPP <= 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- spi_sof  input  1  one-cycle start-of-frame strobe from the SPI slave.
- spi_wr  input  1  one-cycle byte-valid strobe.
- spi_wr_data  input  8  byte qualified by spi_wr.
- fb_we  output  1  frame buffer write enable (one-cycle pulse per byte).
- fb_addr  output  ADDR_W  frame buffer byte address.
- fb_data  output  8  frame buffer write data.
- je_start  output  1  one-cycle encoder start pulse.
- je_done  input  1  encoder finished (level or pulse).
- busy  output  1  high whenever state != IDLE.
- err  output  1  sticky protocol-error flag.
- err_clr  input  1  clears err.

Behaviour:
- Reset values: state=IDLE; fb_we, je_start, err = 0; fb_addr, fb_data = 0; byte_idx, col, row = 0. busy is therefore 0 after reset.
- Reset mid-frame aborts immediately. No je_start is issued, and a new spi_sof is required.
- Counters:
  - byte_idx is 0..BPP-1, col is 0..WIDTH-1, row is 0..HEIGHT-1.
  - byte_idx wraps to 0 and increments col; col wraps to 0 and increments row.
- Address:
  - Computed as row*WIDTH*BPP + col*BPP + eff_idx, where eff_idx = (SWAP_BYTES && BPP==2) ? 1-byte_idx : byte_idx.
  - Result is truncated to ADDR_W. Multiplies by constants are allowed.
- States:
  - IDLE: spi_sof -> RX with all counters cleared. spi_wr alone in IDLE is dropped and sets err.
  - RX: each spi_wr registers fb_data=spi_wr_data and fb_addr=address(current counters), with fb_we=1 on the next cycle (write latency exactly 1 cycle); the counters then advance. The byte with row=HEIGHT-1, col=WIDTH-1, byte_idx=BPP-1 is written and the state goes to START.
  - START: je_start=1 for exactly one cycle, then BUSY.
  - BUSY: stays until je_done=1, then IDLE. je_done seen in any other state is ignored.
- Error rules:
  - spi_sof in RX while any counter is non-zero: counters restart at 0, state stays RX, err set (truncated frame).
  - spi_sof and spi_wr in the same cycle (IDLE or RX): sof wins and the byte is accepted as byte 0 of the new frame, written to address(0,0,0). Only the mid-frame restart sets err.
  - spi_wr or spi_sof in START or BUSY: dropped, no fb_we, err set.
- err:
  - Sticky until err_clr.
  - err_clr and a new error in the same cycle: err stays 1 (set wins).
- fb_we is never asserted outside the cycle following an accepted spi_wr. Back-to-back spi_wr on consecutive cycles is supported at full rate.

Test Plan:
- Reset, spi_sof, then bytes 0x00..0xFF repeating for 128000 bytes -> fb_we pulses exactly 128000 times; byte n is written to fb_addr=n with fb_data=n&0xFF; je_start pulses once, 1 cycle after the final fb_we; busy=1 until je_done.
- SWAP_BYTES=1: spi_sof, then bytes 0xAA, 0xBB, 0xCC -> writes (addr 1, 0xAA), (addr 0, 0xBB), (addr 3, 0xCC). Column wrap: byte 640 (row 1, col 0) lands at address 641.
- After 10 bytes, spi_sof then 1 byte 0x55 -> err=1; 0x55 is written to addr 0. err_clr clears err.
- During BUSY, spi_wr 0x12 -> no fb_we, err=1. je_done -> IDLE, busy=0. The next spi_sof is accepted.
- Assert reset while row=50 mid-frame -> all outputs return to reset values; no je_start follows; spi_wr before spi_sof sets err.
- spi_sof and spi_wr(0x77) in the same cycle from IDLE -> fb_addr=0, fb_data=0x77, err remains 0.

Source files
------------

// File: rtl/spi_to_jpeg_data_if.sv
// Bundle of the SPI ingress strobes, frame buffer write port and encoder
// handshake used between the host side and spi_to_jpeg_data.
interface spi_to_jpeg_data_if #(
    parameter int ADDR_W = 17
);
    logic              spi_sof;
    logic              spi_wr;
    logic [7:0]        spi_wr_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              je_start;
    logic              je_done;
    logic              busy;
    logic              err;
    logic              err_clr;

    modport master (
        output spi_sof, spi_wr, spi_wr_data, je_done, err_clr,
        input  fb_we, fb_addr, fb_data, je_start, busy, err
    );

    modport slave (
        input  spi_sof, spi_wr, spi_wr_data, je_done, err_clr,
        output fb_we, fb_addr, fb_data, je_start, busy, err
    );
endinterface

// File: rtl/spi_to_jpeg_data.sv
// Writes SPI pixel bytes in raster order into the encoder frame buffer,
// then kicks the encoder and holds off the host until it reports done.
module spi_to_jpeg_data #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 200,
    parameter int BPP        = 2,
    parameter int SWAP_BYTES = 0,
    parameter int ADDR_W     = 17
) (
    input logic               clk,
    input logic               reset,
    spi_to_jpeg_data_if.slave bus
);
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(HEIGHT - 1);
    localparam logic              BYTE_LAST  = (BPP == 2);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WIDTH * BPP);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(BPP);
    localparam logic              DO_SWAP    = (SWAP_BYTES != 0) && (BPP == 2);

    typedef enum logic [1:0] {IDLE, RX, START, BUSY} state_t;

    state_t            state, state_next;
    logic              byte_idx, byte_next, base_byte, eff_idx;
    logic [COL_W-1:0]  col, col_next, base_col;
    logic [ROW_W-1:0]  row, row_next, base_row;
    logic              fb_we_q, fb_we_next;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_next, addr_calc;
    logic [7:0]        fb_data_q, fb_data_next;
    logic              je_start_q, je_start_next;
    logic              err_q, err_next, err_set;
    logic              sof_take, wr_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_idx   <= 1'b0;
            col        <= '0;
            row        <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            je_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            byte_idx   <= byte_next;
            col        <= col_next;
            row        <= row_next;
            fb_we_q    <= fb_we_next;
            fb_addr_q  <= fb_addr_next;
            fb_data_q  <= fb_data_next;
            je_start_q <= je_start_next;
            err_q      <= err_next;
        end
    end

    // A start-of-frame takes priority and rebases the counters, so a byte
    // arriving in the same cycle is written as byte 0 of the new frame.
    always_comb begin
        state_next    = state;
        byte_next     = byte_idx;
        col_next      = col;
        row_next      = row;
        fb_we_next    = 1'b0;
        fb_addr_next  = fb_addr_q;
        fb_data_next  = fb_data_q;
        je_start_next = (state == START);
        err_set       = 1'b0;

        sof_take  = bus.spi_sof && ((state == IDLE) || (state == RX));
        wr_take   = bus.spi_wr && ((state == RX) || ((state == IDLE) && bus.spi_sof));
        base_byte = sof_take ? 1'b0 : byte_idx;
        base_col  = sof_take ? '0 : col;
        base_row  = sof_take ? '0 : row;
        eff_idx   = DO_SWAP ? ~base_byte : base_byte;
        addr_calc = ADDR_W'(base_row) * ROW_STRIDE + ADDR_W'(base_col) * COL_STRIDE
                  + ADDR_W'(eff_idx);

        case (state)
            IDLE: begin
                if (!bus.spi_sof && bus.spi_wr) err_set = 1'b1;
            end
            RX: begin
                if (bus.spi_sof && ((byte_idx != 1'b0) || (col != '0) || (row != '0)))
                    err_set = 1'b1;
            end
            START: begin
                state_next = BUSY;
                if (bus.spi_sof || bus.spi_wr) err_set = 1'b1;
            end
            BUSY: begin
                if (bus.je_done) state_next = IDLE;
                if (bus.spi_sof || bus.spi_wr) err_set = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (sof_take) begin
            state_next = RX;
            byte_next  = 1'b0;
            col_next   = '0;
            row_next   = '0;
        end

        if (wr_take) begin
            fb_we_next   = 1'b1;
            fb_addr_next = addr_calc;
            fb_data_next = bus.spi_wr_data;
            if (base_byte != BYTE_LAST) begin
                byte_next = 1'b1;
            end else begin
                byte_next = 1'b0;
                if (base_col != COL_LAST) begin
                    col_next = base_col + 1'b1;
                end else begin
                    col_next = '0;
                    if (base_row != ROW_LAST) begin
                        row_next = base_row + 1'b1;
                    end else begin
                        row_next   = '0;
                        state_next = START;
                    end
                end
            end
        end

        err_next = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_data  = fb_data_q;
    assign bus.je_start = je_start_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_spi_to_jpeg_data.sv
// Directed bench: a reduced 8x4x2 instance for full frames and error paths,
// and a full-size byte-swapping instance for swap order and row wrap.
module tb_spi_to_jpeg_data;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   we_count0 = 0;
    int   start_count0 = 0;

    spi_to_jpeg_data_if #(.ADDR_W(17)) b0 ();
    spi_to_jpeg_data_if #(.ADDR_W(17)) b1 ();

    spi_to_jpeg_data #(.WIDTH(8), .HEIGHT(4), .BPP(2), .SWAP_BYTES(0), .ADDR_W(17)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave));
    spi_to_jpeg_data #(.WIDTH(320), .HEIGHT(200), .BPP(2), .SWAP_BYTES(1), .ADDR_W(17)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b0.fb_we) we_count0++;
        if (b0.je_start) start_count0++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs are set on a falling edge and cleared one cycle later, so on
    // return the outputs already reflect the rising edge that sampled them.
    task automatic applyStimulus(input int which, input logic sof, input logic wr,
                                 input logic [7:0] data, input logic clr);
        if (which == 0) begin
            b0.spi_sof = sof; b0.spi_wr = wr; b0.spi_wr_data = data; b0.err_clr = clr;
        end else begin
            b1.spi_sof = sof; b1.spi_wr = wr; b1.spi_wr_data = data; b1.err_clr = clr;
        end
        @(negedge clk);
        b0.spi_sof = 1'b0; b0.spi_wr = 1'b0; b0.err_clr = 1'b0;
        b1.spi_sof = 1'b0; b1.spi_wr = 1'b0; b1.err_clr = 1'b0;
    endtask

    initial begin
        b0.spi_sof = 0; b0.spi_wr = 0; b0.spi_wr_data = 0; b0.je_done = 0; b0.err_clr = 0;
        b1.spi_sof = 0; b1.spi_wr = 0; b1.spi_wr_data = 0; b1.je_done = 0; b1.err_clr = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("rst_we", 32'(b0.fb_we), 0);
        checkOutput("rst_addr", 32'(b0.fb_addr), 0);
        checkOutput("rst_data", 32'(b0.fb_data), 0);
        checkOutput("rst_start", 32'(b0.je_start), 0);
        checkOutput("rst_busy", 32'(b0.busy), 0);
        checkOutput("rst_err", 32'(b0.err), 0);

        // Full 64-byte frame: byte n lands at address n
        applyStimulus(0, 1, 0, 8'h00, 0);
        checkOutput("sof_busy", 32'(b0.busy), 1);
        checkOutput("sof_no_we", 32'(b0.fb_we), 0);
        for (int n = 0; n < 64; n++) begin
            applyStimulus(0, 0, 1, 8'(n), 0);
            checkOutput("frame_we", 32'(b0.fb_we), 1);
            checkOutput("frame_addr", 32'(b0.fb_addr), 32'(n));
            checkOutput("frame_data", 32'(b0.fb_data), 32'(n));
        end
        checkOutput("start_early", 32'(b0.je_start), 0);
        @(negedge clk);
        checkOutput("start_pulse", 32'(b0.je_start), 1);
        checkOutput("start_no_we", 32'(b0.fb_we), 0);
        @(negedge clk);
        checkOutput("start_end", 32'(b0.je_start), 0);
        checkOutput("busy_hold", 32'(b0.busy), 1);
        checkOutput("we_total", 32'(we_count0), 64);

        // Traffic while the encoder runs is dropped and flagged
        applyStimulus(0, 0, 1, 8'h12, 0);
        checkOutput("busy_wr_no_we", 32'(b0.fb_we), 0);
        checkOutput("busy_wr_err", 32'(b0.err), 1);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("clr_vs_set", 32'(b0.err), 1);
        checkOutput("busy_sof_stay", 32'(b0.busy), 1);
        b0.je_done = 1'b1;
        @(negedge clk);
        b0.je_done = 1'b0;
        checkOutput("done_idle", 32'(b0.busy), 0);
        checkOutput("start_once", 32'(start_count0), 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("err_clr", 32'(b0.err), 0);
        checkOutput("we_after_busy", 32'(we_count0), 64);

        // Truncated frame restart
        applyStimulus(0, 1, 0, 8'h00, 0);
        checkOutput("resof_busy", 32'(b0.busy), 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 8'(i + 8'h20), 0);
        checkOutput("trunc_addr9", 32'(b0.fb_addr), 9);
        checkOutput("trunc_no_err", 32'(b0.err), 0);
        applyStimulus(0, 1, 0, 8'h00, 0);
        checkOutput("trunc_err", 32'(b0.err), 1);
        applyStimulus(0, 0, 1, 8'h55, 0);
        checkOutput("trunc_we", 32'(b0.fb_we), 1);
        checkOutput("trunc_addr", 32'(b0.fb_addr), 0);
        checkOutput("trunc_data", 32'(b0.fb_data), 32'h55);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("trunc_clr", 32'(b0.err), 0);

        // Mid-frame sof together with a byte: restart with that byte at 0
        applyStimulus(0, 1, 1, 8'h99, 0);
        checkOutput("mid_sofwr_addr", 32'(b0.fb_addr), 0);
        checkOutput("mid_sofwr_data", 32'(b0.fb_data), 32'h99);
        checkOutput("mid_sofwr_err", 32'(b0.err), 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        for (int i = 1; i <= 40; i++) applyStimulus(0, 0, 1, 8'(i), 0);
        checkOutput("row2_addr", 32'(b0.fb_addr), 40);

        // Asynchronous reset in row 2 aborts the frame
        reset = 1'b1;
        #1;
        checkOutput("arst_we", 32'(b0.fb_we), 0);
        checkOutput("arst_addr", 32'(b0.fb_addr), 0);
        checkOutput("arst_data", 32'(b0.fb_data), 0);
        checkOutput("arst_busy", 32'(b0.busy), 0);
        checkOutput("arst_err", 32'(b0.err), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("arst_no_start", 32'(start_count0), 1);
        applyStimulus(0, 0, 1, 8'h33, 0);
        checkOutput("idle_wr_err", 32'(b0.err), 1);
        checkOutput("idle_wr_no_we", 32'(b0.fb_we), 0);
        checkOutput("idle_wr_busy", 32'(b0.busy), 0);
        applyStimulus(0, 0, 0, 8'h00, 1);

        // sof and byte together from idle
        applyStimulus(0, 1, 1, 8'h77, 0);
        checkOutput("idle_sofwr_we", 32'(b0.fb_we), 1);
        checkOutput("idle_sofwr_addr", 32'(b0.fb_addr), 0);
        checkOutput("idle_sofwr_data", 32'(b0.fb_data), 32'h77);
        checkOutput("idle_sofwr_err", 32'(b0.err), 0);
        applyStimulus(0, 0, 1, 8'h78, 0);
        checkOutput("idle_sofwr_next", 32'(b0.fb_addr), 1);

        // Byte-swapped full-size instance
        applyStimulus(1, 1, 0, 8'h00, 0);
        applyStimulus(1, 0, 1, 8'hAA, 0);
        checkOutput("swap_addr0", 32'(b1.fb_addr), 1);
        checkOutput("swap_data0", 32'(b1.fb_data), 32'hAA);
        applyStimulus(1, 0, 1, 8'hBB, 0);
        checkOutput("swap_addr1", 32'(b1.fb_addr), 0);
        checkOutput("swap_data1", 32'(b1.fb_data), 32'hBB);
        applyStimulus(1, 0, 1, 8'hCC, 0);
        checkOutput("swap_addr2", 32'(b1.fb_addr), 3);
        checkOutput("swap_data2", 32'(b1.fb_data), 32'hCC);
        for (int n = 3; n < 640; n++) applyStimulus(1, 0, 1, 8'(n), 0);
        applyStimulus(1, 0, 1, 8'h80, 0);
        checkOutput("swap_row1_b0", 32'(b1.fb_addr), 641);
        applyStimulus(1, 0, 1, 8'h81, 0);
        checkOutput("swap_row1_b1", 32'(b1.fb_addr), 640);
        checkOutput("swap_err", 32'(b1.err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
